// File: rtl/fp_seq_pkg.sv
// ============================================================================
// Module   : fp_seq_pkg
// Purpose  : Shared opcodes, exception-flag bit positions, canonical quiet NaN
//            and FSM state encoding for the FPU command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_seq_pkg;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SQRT = 2'b11;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] QNAN_32 = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/fp_seq_watchdog.sv
// ============================================================================
// Module   : fp_seq_watchdog
// Purpose  : Cycle counter with clear/enable; tc fires in the cycle the count
//            reaches LIMIT. LIMIT = 0 disables the terminal count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_seq_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  generate
    if (LIMIT == 0) begin : g_wd_off
      assign tc = 1'b0;
    end else begin : g_wd_on
      // Fires on the cycle whose increment would make the count equal LIMIT.
      assign tc = en && (count_q == CNT_W'(LIMIT - 1));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/fp_cmd_sequencer.sv
// ============================================================================
// Module   : fp_cmd_sequencer
// Purpose  : Tagged command front end for the FPU: issues one operation,
//            waits for done (watchdog bounded) and returns a tagged response.
//            Optional sticky exception flags: FP_SEQ_STICKY_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_cmd_sequencer
  import fp_seq_pkg::*;
#(
  parameter int D_WIDTH        = 32,
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [D_WIDTH-1:0] cmd_a,
  input  logic [D_WIDTH-1:0] cmd_b,
  input  logic [1:0]         cmd_op,
  input  logic [1:0]         cmd_rm,
  input  logic [TAG_W-1:0]   cmd_tag,
  output logic               fpu_input_ready,
  output logic [D_WIDTH-1:0] fpu_a,
  output logic [D_WIDTH-1:0] fpu_b,
  output logic [1:0]         fpu_op,
  output logic [1:0]         fpu_round_mode,
  input  logic [D_WIDTH-1:0] fpu_z,
  input  logic               fpu_done,
  input  logic               fpu_busy,
  input  logic               fpu_of,
  input  logic               fpu_uf,
  input  logic               fpu_dz,
  input  logic               fpu_nx,
  input  logic               fpu_nv,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [D_WIDTH-1:0] rsp_z,
  output logic [4:0]         rsp_flags,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic [1:0]         rsp_op,
  output logic               rsp_timeout
`ifdef FP_SEQ_STICKY_FLAGS_EN
  ,
  input  logic               fflags_clr,
  output logic [4:0]         fflags
`endif
);

  seq_state_e         state_q, state_d;
  logic [D_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]         op_q, op_d, rm_q, rm_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [D_WIDTH-1:0] rsp_z_q, rsp_z_d;
  logic [4:0]         rsp_flags_q, rsp_flags_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic [1:0]         rsp_op_q, rsp_op_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic [4:0]         fpu_flags;
  logic               wd_tc;

  fp_seq_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != WAIT),
    .en    (state_q == WAIT),
    .tc    (wd_tc)
  );

  always_comb begin
    fpu_flags          = '0;
    fpu_flags[FLAG_NV] = fpu_nv;
    fpu_flags[FLAG_DZ] = fpu_dz;
    fpu_flags[FLAG_OF] = fpu_of;
    fpu_flags[FLAG_UF] = fpu_uf;
    fpu_flags[FLAG_NX] = fpu_nx;
  end

  // Gated by reset so every output reads 0 while reset is held, even in IDLE.
  assign cmd_ready = (state_q == IDLE) && !reset;

  always_comb begin
    state_d         = state_q;
    a_d             = a_q;
    b_d             = b_q;
    op_d            = op_q;
    rm_d            = rm_q;
    tag_d           = tag_q;
    rsp_z_d         = rsp_z_q;
    rsp_flags_d     = rsp_flags_q;
    rsp_tag_d       = rsp_tag_q;
    rsp_op_d        = rsp_op_q;
    rsp_timeout_d   = rsp_timeout_q;
    fpu_input_ready = 1'b0;
    rsp_valid       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          op_d    = cmd_op;
          rm_d    = cmd_rm;
          tag_d   = cmd_tag;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!fpu_busy) begin
          fpu_input_ready = 1'b1;
          state_d         = WAIT;
        end
      end
      WAIT: begin
        // A done arriving on the watchdog's terminal cycle takes priority.
        if (fpu_done) begin
          rsp_z_d       = fpu_z;
          rsp_flags_d   = fpu_flags;
          rsp_timeout_d = 1'b0;
          rsp_tag_d     = tag_q;
          rsp_op_d      = op_q;
          state_d       = RESP;
        end else if (wd_tc) begin
          rsp_z_d       = D_WIDTH'(QNAN_32);
          rsp_flags_d   = '0;
          rsp_timeout_d = 1'b1;
          rsp_tag_d     = tag_q;
          rsp_op_d      = op_q;
          state_d       = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      rm_q          <= '0;
      tag_q         <= '0;
      rsp_z_q       <= '0;
      rsp_flags_q   <= '0;
      rsp_tag_q     <= '0;
      rsp_op_q      <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      rm_q          <= rm_d;
      tag_q         <= tag_d;
      rsp_z_q       <= rsp_z_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_op_q      <= rsp_op_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign fpu_a          = a_q;
  assign fpu_b          = b_q;
  assign fpu_op         = op_q;
  assign fpu_round_mode = rm_q;
  assign rsp_z          = rsp_z_q;
  assign rsp_flags      = rsp_flags_q;
  assign rsp_tag        = rsp_tag_q;
  assign rsp_op         = rsp_op_q;
  assign rsp_timeout    = rsp_timeout_q;

`ifdef FP_SEQ_STICKY_FLAGS_EN
  logic [4:0] fflags_q, fflags_d;

  // A clear coinciding with a handshake keeps only the new response's flags.
  always_comb begin
    fflags_d = fflags_clr ? 5'b0 : fflags_q;
    if (rsp_valid && rsp_ready) begin
      fflags_d = fflags_d | rsp_flags_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fflags_q <= '0;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  assign fflags = fflags_q;
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_cmd_sequencer.sv
// ============================================================================
// Module   : tb_fp_cmd_sequencer
// Purpose  : Self-checking bench for fp_cmd_sequencer with a 5-cycle FPU stub
//            and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_cmd_sequencer;
  import fp_seq_pkg::*;

  localparam int DW  = 32;
  localparam int TW  = 4;
  localparam int TO  = 16;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [DW-1:0] cmd_a, cmd_b;
  logic [1:0]    cmd_op, cmd_rm;
  logic [TW-1:0] cmd_tag;
  logic          fpu_input_ready;
  logic [DW-1:0] fpu_a, fpu_b;
  logic [1:0]    fpu_op, fpu_round_mode;
  logic [DW-1:0] fpu_z;
  logic          fpu_done, fpu_busy;
  logic          fpu_of, fpu_uf, fpu_dz, fpu_nx, fpu_nv;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_z;
  logic [4:0]    rsp_flags;
  logic [TW-1:0] rsp_tag;
  logic [1:0]    rsp_op;
  logic          rsp_timeout;
`ifdef FP_SEQ_STICKY_FLAGS_EN
  logic          fflags_clr = 1'b0;
  logic [4:0]    fflags;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fp_cmd_sequencer #(
    .D_WIDTH        (DW),
    .TAG_W          (TW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_a           (cmd_a),
    .cmd_b           (cmd_b),
    .cmd_op          (cmd_op),
    .cmd_rm          (cmd_rm),
    .cmd_tag         (cmd_tag),
    .fpu_input_ready (fpu_input_ready),
    .fpu_a           (fpu_a),
    .fpu_b           (fpu_b),
    .fpu_op          (fpu_op),
    .fpu_round_mode  (fpu_round_mode),
    .fpu_z           (fpu_z),
    .fpu_done        (fpu_done),
    .fpu_busy        (fpu_busy),
    .fpu_of          (fpu_of),
    .fpu_uf          (fpu_uf),
    .fpu_dz          (fpu_dz),
    .fpu_nx          (fpu_nx),
    .fpu_nv          (fpu_nv),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_z           (rsp_z),
    .rsp_flags       (rsp_flags),
    .rsp_tag         (rsp_tag),
    .rsp_op          (rsp_op),
    .rsp_timeout     (rsp_timeout)
`ifdef FP_SEQ_STICKY_FLAGS_EN
    ,
    .fflags_clr      (fflags_clr),
    .fflags          (fflags)
`endif
  );

  // ---------------- FPU stub: fixed latency, small result table -------------
  logic [LAT-1:0] pipe = '0;
  logic [DW-1:0]  stub_z = '0;
  logic [4:0]     stub_flags = '0;
  int             issue_cnt = 0;
  logic           stub_busy = 1'b0;
  logic           stub_mute = 1'b0;
  logic           done_force = 1'b0;

  function automatic logic [36:0] stub_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [36:0] r;
    r = {5'b00001, 32'h0};
    case (op)
      OP_MULT: if (a == 32'h4000_0000 && b == 32'h4040_0000) r = {5'b00000, 32'h40C0_0000};
      OP_DIV:  if (b == 32'h0) r = {5'b01000, 32'h7F80_0000};
      OP_ADD:  if (a == 32'h3F80_0000 && b == 32'h3F80_0000) r = {5'b00000, 32'h4000_0000};
      OP_SQRT: if (a == 32'h4080_0000) r = {5'b00000, 32'h4000_0000};
      default: r = {5'b00001, 32'h0};
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    pipe <= {pipe[LAT-2:0], fpu_input_ready};
    if (fpu_input_ready) begin
      {stub_flags, stub_z} <= stub_model(fpu_op, fpu_a, fpu_b);
      issue_cnt <= issue_cnt + 1;
    end
  end

  assign fpu_z    = stub_z;
  assign fpu_done = (pipe[LAT-1] & ~stub_mute) | done_force;
  assign fpu_busy = stub_busy | (|pipe);
  assign {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx} = stub_flags;

  // ---------------- scoreboard ----------------------------------------------
  typedef struct {
    logic [31:0] z;
    logic [4:0]  flags;
    logic [3:0]  tag;
    logic [1:0]  op;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Called at posedge+1; returns the cycle number of the accept cycle.
  task automatic send_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] rm, input logic [3:0] tag,
                          input logic [31:0] ez, input logic [4:0] ef, input logic eto,
                          output int acc);
    exp_t e;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_rm = rm; cmd_tag = tag;
    acc = -1;
    for (int i = 0; i < 50 && acc < 0; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = cyc;
        e.z = ez; e.flags = ef; e.tag = tag; e.op = op; e.to = eto;
        sb.push_back(e);
      end
    end
    if (acc < 0) begin
      n_tests++; n_fail++;
      $display("FAIL cmd_accept: cmd_ready never seen, required 1");
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Waits for a response handshake and checks it against the scoreboard.
  task automatic collect_rsp(output int vc);
    exp_t e;
    vc = -1;
    for (int i = 0; i < 100 && vc < 0; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        vc = cyc;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: got z=%h tag=%0d, required no response", rsp_z, rsp_tag);
        end else begin
          e = sb.pop_front();
          if (rsp_z !== e.z || rsp_flags !== e.flags || rsp_tag !== e.tag ||
              rsp_op !== e.op || rsp_timeout !== e.to) begin
            n_fail++;
            $display("FAIL rsp_fields: got z=%h fl=%b tag=%0d op=%0d to=%b, required z=%h fl=%b tag=%0d op=%0d to=%b",
                     rsp_z, rsp_flags, rsp_tag, rsp_op, rsp_timeout, e.z, e.flags, e.tag, e.op, e.to);
          end
        end
      end
    end
    if (vc < 0) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_wait: no response handshake within 100 cycles, required one");
    end
    @(posedge clk); #1;
  endtask

  task automatic find_issue(output int k);
    k = -1;
    for (int i = 0; i < 50 && k < 0; i++) begin
      @(negedge clk);
      if (fpu_input_ready) k = cyc;
    end
    if (k < 0) begin
      n_tests++; n_fail++;
      $display("FAIL issue_wait: fpu_input_ready never seen, required 1");
    end
  endtask

  // ---------------- scenarios -----------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || fpu_input_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready=%b valid=%b ir=%b, required 0 0 0", cmd_ready, rsp_valid, fpu_input_ready);
    end
    n_tests++;
    if ({fpu_a, fpu_b, fpu_op, fpu_round_mode} !== '0 ||
        {rsp_z, rsp_flags, rsp_tag, rsp_op, rsp_timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got a=%h b=%h z=%h fl=%b tag=%0d, required all 0", fpu_a, fpu_b, rsp_z, rsp_flags, rsp_tag);
    end
    #2 reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready: got cmd_ready=%b, required 1", cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    int acc, vc;
    send_cmd(OP_MULT, 32'h4000_0000, 32'h4040_0000, 2'b00, 4'd3, 32'h40C0_0000, 5'b00000, 1'b0, acc);
    collect_rsp(vc);
    n_tests++;
    if (vc - acc !== 7) begin
      n_fail++;
      $display("FAIL mult_latency: got %0d cycles, required 7", vc - acc);
    end
  endtask

  task automatic test_div();
    int acc, vc;
    send_cmd(OP_DIV, 32'h3F80_0000, 32'h0, 2'b01, 4'd5, 32'h7F80_0000, 5'b01000, 1'b0, acc);
    collect_rsp(vc);
  endtask

  task automatic test_busy_sqrt();
    int acc, vc, i0;
    stub_busy = 1'b1;
    i0 = issue_cnt;
    send_cmd(OP_SQRT, 32'h4080_0000, 32'hDEAD_BEEF, 2'b10, 4'd7, 32'h4000_0000, 5'b00000, 1'b0, acc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (fpu_input_ready !== 1'b0 || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_hold[%0d]: got ir=%b ready=%b, required 0 0", i, fpu_input_ready, cmd_ready);
      end
      @(posedge clk); #1;
    end
    stub_busy = 1'b0;
    @(negedge clk);
    n_tests++;
    if (fpu_input_ready !== 1'b1 || fpu_a !== 32'h4080_0000 || fpu_op !== OP_SQRT || fpu_round_mode !== 2'b10) begin
      n_fail++;
      $display("FAIL busy_issue: got ir=%b a=%h op=%0d rm=%0d, required 1 40800000 3 2", fpu_input_ready, fpu_a, fpu_op, fpu_round_mode);
    end
    @(posedge clk); #1;
    collect_rsp(vc);
    n_tests++;
    if (issue_cnt - i0 !== 1) begin
      n_fail++;
      $display("FAIL issue_count: got %0d issue pulses, required 1", issue_cnt - i0);
    end
  endtask

  task automatic test_timeout();
    int acc, k, vc;
    logic saw;
    stub_mute = 1'b1;
    send_cmd(OP_MULT, 32'h4000_0000, 32'h4040_0000, 2'b00, 4'd11, 32'h7FC0_0000, 5'b00000, 1'b1, acc);
    find_issue(k);
    collect_rsp(vc);
    n_tests++;
    if (vc !== k + 1 + TO) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles after WAIT entry, required %0d", vc - k - 1, TO);
    end
    stub_mute = 1'b0;
    done_force = 1'b1;
    @(posedge clk); #1;
    done_force = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    n_tests++;
    if (saw !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL late_done: got rsp_valid_seen=%b ready=%b, required 0 1", saw, cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acc, vc;
    logic got;
    exp_t e;
    rsp_ready = 1'b0;
    send_cmd(OP_ADD, 32'h3F80_0000, 32'h3F80_0000, 2'b11, 4'd9, 32'h4000_0000, 5'b00000, 1'b0, acc);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = OP_MULT; cmd_a = 32'h4000_0000; cmd_b = 32'h4040_0000;
    cmd_rm = 2'b00; cmd_tag = 4'd10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_z !== 32'h4000_0000 || rsp_tag !== 4'd9 || rsp_op !== OP_ADD ||
          rsp_flags !== 5'b0 || rsp_timeout !== 1'b0 || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall[%0d]: got valid=%b z=%h tag=%0d op=%0d ready=%b, required 1 40000000 9 2 0",
                 i, rsp_valid, rsp_z, rsp_tag, rsp_op, cmd_ready);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    collect_rsp(vc);
    // Back in IDLE now: the pending command is accepted in this cycle.
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_accept: got ready=%b valid=%b, required 1 0", cmd_ready, rsp_valid);
    end else begin
      e.z = 32'h40C0_0000; e.flags = 5'b0; e.tag = 4'd10; e.op = OP_MULT; e.to = 1'b0;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    collect_rsp(vc);
  endtask

  task automatic test_reset_mid();
    int acc, k;
    logic saw;
    exp_t e;
    send_cmd(OP_MULT, 32'h4000_0000, 32'h4040_0000, 2'b01, 4'd12, 32'h40C0_0000, 5'b0, 1'b0, acc);
    e = sb.pop_back();
    find_issue(k);
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || fpu_input_ready !== 1'b0 ||
        {fpu_a, fpu_b, fpu_op, fpu_round_mode} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got ready=%b valid=%b ir=%b a=%h rm=%0d, required all 0",
               cmd_ready, rsp_valid, fpu_input_ready, fpu_a, fpu_round_mode);
    end
    @(posedge clk); #3;
    reset = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    n_tests++;
    if (saw !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL done_after_reset: got rsp_valid_seen=%b ready=%b, required 0 1", saw, cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_rm = '0; cmd_tag = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_mult();
    test_div();
    test_busy_sqrt();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    n_tests++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d outstanding responses, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/fp_cmd_sequencer.md
Name: fp_cmd_sequencer

Overview:
- Initiator-side front end for the floating-point unit (fp_unit_new).
- Accepts tagged operation commands over a valid/ready interface and drives the FPU's input_ready/a/b/op/round_mode port.
- Waits for done, captures z and the exception flags, and returns a tagged response over a second valid/ready interface.
- One operation in flight; a watchdog bounds the wait for done.

Parameters:
- D_WIDTH, 32, operand/result width (single precision).
- TAG_W, 4, command tag width.
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT before timeout abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_a, cmd_b  in  D_WIDTH  operands; cmd_b is ignored for sqrt.
- cmd_op  in  2  00 mult, 01 div, 10 add, 11 sqrt.
- cmd_rm  in  2  rounding mode.
- cmd_tag  in  TAG_W  returned unchanged with the response.
- fpu_input_ready  out  1  issue strobe to the FPU.
- fpu_a, fpu_b  out  D_WIDTH  operands to the FPU.
- fpu_op  out  2  operation code to the FPU.
- fpu_round_mode  out  2  rounding mode to the FPU.
- fpu_z  in  D_WIDTH  FPU result.
- fpu_done  in  1  result valid, single-cycle pulse.
- fpu_busy  in  1  FPU computing.
- fpu_of, fpu_uf, fpu_dz, fpu_nx, fpu_nv  in  1 each  FPU exception flags.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_z  out  D_WIDTH  result.
- rsp_flags  out  5  {nv,dz,of,uf,nx}.
- rsp_tag  out  TAG_W  tag of the completed command.
- rsp_op  out  2  opcode of the completed command.
- rsp_timeout  out  1  set when the operation was aborted by the watchdog.

Behaviour:
- Reset values: all outputs 0; state IDLE; watchdog counter 0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, register a/b/op/rm/tag and go to ISSUE.
  - cmd_ready is 0 in every other state.
- ISSUE:
  - If !fpu_busy: fpu_input_ready=1 for exactly one cycle, then go to WAIT.
  - Otherwise hold in ISSUE with fpu_input_ready=0.
- fpu_a/b/op/round_mode are driven from the registers and held stable from ISSUE until WAIT exits.
- WAIT:
  - Counter increments each cycle.
  - On fpu_done: capture fpu_z and flags, rsp_timeout=0, go to RESP.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES without done: rsp_z=32'h7FC00000, rsp_flags=0, rsp_timeout=1, go to RESP.
  - fpu_done in the same cycle the counter reaches the limit: done wins.
- RESP:
  - rsp_valid=1; all rsp_* fields stay stable until rsp_valid&&rsp_ready, then return to IDLE.
  - rsp_valid then deasserts the next cycle.
- fpu_done outside WAIT is ignored (covers late completion after a timeout and completion after a reset).
- Minimum latency from command accept to rsp_valid = 2 + FPU latency cycles.
- Reset mid-operation: immediate return to IDLE and all outputs 0. The FPU itself is not reset by this block.
- Back-to-back operation: a new command is accepted only in the cycle after the response handshake (IDLE).

Optional Feature:
- FP_SEQ_STICKY_FLAGS_EN.
- When defined, adds:
  - input fflags_clr: 1-bit, synchronous clear.
  - output fflags: 5 bits, ORs rsp_flags of every completed response handshake.
  - clr together with a handshake in the same cycle: the result is the new flags only.
  - Reset value of fflags: 0.
- When undefined, neither port nor register exists.

Decomposition:
- Package fp_seq_pkg holds:
  - opcode constants OP_MULT/OP_DIV/OP_ADD/OP_SQRT.
  - flag bit indices FLAG_NV..FLAG_NX.
  - the QNAN_32 constant.
  - the state enum IDLE/ISSUE/WAIT/RESP.
- One natural sub-module, fp_seq_watchdog: a counter with clear/enable/limit and a terminal-count output.

Test Plan:
- Bench uses an FPU stub with a 5-cycle latency.
- mult 0x40000000*0x40400000, tag 3 → rsp_z=0x40C00000, rsp_flags=0, rsp_tag=3, rsp_valid 7 cycles after accept.
- div 0x3F800000/0x00000000 → rsp_z=0x7F800000, rsp_flags=5'b01000 (dz).
- sqrt 0x40800000 issued while fpu_busy is held high 3 cycles → fpu_input_ready is delayed 3 cycles, then pulses once; rsp_z=0x40000000.
- Timeout: TIMEOUT_CYCLES=16 and the stub never asserts done → rsp_timeout=1, rsp_z=0x7FC00000 16 cycles after WAIT entry; a later fpu_done is ignored.
- Backpressure: rsp_ready low for 5 cycles → rsp_* stable, cmd_ready=0 throughout; accept resumes the cycle after the handshake.
- reset asserted in WAIT → all outputs 0 asynchronously; the stub's subsequent done produces no response.
